// File: rtl/lcd_text_frame_pkg.sv
// Shared constants, FSM state type and reset-frame helper for the LCD text frame feeder.
package lcd_pkg;

    localparam int FRAME_LEN = 32;
    localparam int LINE_LEN  = 16;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] GLYPH0      = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2
    } state_t;

    // Character held at a position before any frame has been published.
    function automatic logic [7:0] reset_char(input logic [4:0] pos, input bit glyph_en);
        return (pos == 5'd15 && glyph_en) ? GLYPH0 : ASCII_SPACE;
    endfunction

endpackage

// File: rtl/lcd_text_frame_if.sv
// Request/readout bundle between the LCD controller side and the text frame feeder.
interface lcd_text_frame_if;
    logic        load;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [4:0]  sel;
    logic [7:0]  dd_data;
    logic        busy;
    logic        done;
    logic [7:0]  frame_count;

    modport master (
        output load, a_val, b_val, sel,
        input  dd_data, busy, done, frame_count
    );

    modport slave (
        input  load, a_val, b_val, sel,
        output dd_data, busy, done, frame_count
    );
endinterface

// File: rtl/lcd_text_frame_hex_to_ascii.sv
// Nibble to uppercase hex ASCII digit, purely combinational.
module hex_to_ascii (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);
    always_comb begin
        ascii_o = (nibble_i < 4'd10) ? (8'h30 + {4'h0, nibble_i})
                                     : (8'h37 + {4'h0, nibble_i});
    end
endmodule

// File: rtl/lcd_text_frame.sv
// Double-buffered 32-character hex debug frame for the LCD controller.
// state | meaning
// IDLE  | active bank stable, waiting for load
// FILL  | writing one character per cycle into the shadow bank, idx 0..31
// SWAP  | publish shadow bank, then restart if a load is waiting
module lcd_text_frame
    import lcd_pkg::*;
#(
    parameter logic [7:0] PREFIX_A = 8'h41,
    parameter logic [7:0] PREFIX_B = 8'h42,
    parameter bit         GLYPH_EN = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    lcd_text_frame_if.slave  bus
);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        active_q, active_d;
    logic        pending_q, pending_d;
    logic        done_q, done_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] pa_q, pa_d, pb_q, pb_d;

    logic [7:0]  bank0_q [FRAME_LEN];
    logic [7:0]  bank1_q [FRAME_LEN];

    logic        wr_en;
    logic [7:0]  wr_char;
    logic        line2;
    logic [3:0]  col;
    logic [31:0] val_sel;
    logic [2:0]  nib_sel;
    logic [3:0]  nibble;
    logic [7:0]  nib_ascii;

    assign line2   = (idx_q >= 5'(LINE_LEN));
    assign col     = idx_q[3:0];
    assign val_sel = line2 ? b_q : a_q;
    assign nib_sel = 3'(col - 4'd2);
    // Column 2 shows bits [31:28]; ~nib_sel is 7 - nib_sel.
    assign nibble  = val_sel[{~nib_sel, 2'b00} +: 4];

    hex_to_ascii u_hex (
        .nibble_i (nibble),
        .ascii_o  (nib_ascii)
    );

    always_comb begin
        wr_char = ASCII_SPACE;
        if (col == 4'd0) begin
            wr_char = line2 ? PREFIX_B : PREFIX_A;
        end else if (col == 4'd1) begin
            wr_char = ASCII_COLON;
        end else if (col <= 4'd9) begin
            wr_char = nib_ascii;
        end else if (idx_q == 5'd15 && GLYPH_EN) begin
            wr_char = GLYPH0;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        active_d  = active_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        count_d   = count_q;
        a_d       = a_q;
        b_d       = b_q;
        pa_d      = pa_q;
        pb_d      = pb_q;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    a_d     = bus.a_val;
                    b_d     = bus.b_val;
                    idx_d   = 5'd0;
                    state_d = FILL;
                end
            end
            FILL: begin
                wr_en = 1'b1;
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'(FRAME_LEN - 1)) state_d = SWAP;
                if (bus.load) begin
                    pending_d = 1'b1;
                    pa_d      = bus.a_val;
                    pb_d      = bus.b_val;
                end
            end
            SWAP: begin
                active_d  = ~active_q;
                done_d    = 1'b1;
                count_d   = count_q + 8'd1;
                pending_d = 1'b0;
                idx_d     = 5'd0;
                if (bus.load) begin
                    a_d     = bus.a_val;
                    b_d     = bus.b_val;
                    state_d = FILL;
                end else if (pending_q) begin
                    a_d     = pa_q;
                    b_d     = pb_q;
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 5'd0;
            active_q  <= 1'b0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 8'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            pa_q      <= 32'd0;
            pb_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            count_q   <= count_d;
            a_q       <= a_d;
            b_q       <= b_d;
            pa_q      <= pa_d;
            pb_q      <= pb_d;
        end
    end

    // Only the shadow bank is ever written, so the displayed bank cannot tear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                bank0_q[i] <= reset_char(5'(i), GLYPH_EN);
                bank1_q[i] <= reset_char(5'(i), GLYPH_EN);
            end
        end else if (wr_en) begin
            if (active_q) bank0_q[idx_q] <= wr_char;
            else          bank1_q[idx_q] <= wr_char;
        end
    end

    assign bus.dd_data     = active_q ? bank1_q[bus.sel] : bank0_q[bus.sel];
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.frame_count = count_q;

endmodule

// File: tb/tb_lcd_text_frame.sv
// Randomized and directed bench for lcd_text_frame against a transaction-level frame model.
`timescale 1ns/100ps
module tb_lcd_text_frame;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    lcd_text_frame_if bus ();

    lcd_text_frame dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: displayed frame, cycles left until the build in progress is published, one queued request.
    logic [7:0]  m_frame [32];
    int          m_left;
    logic [31:0] m_cur_a, m_cur_b, m_q_a, m_q_b;
    bit          m_have_q;
    logic        m_done;
    logic [7:0]  m_count;
    string       hx = "0123456789ABCDEF";

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_frame[i] = (i == 15) ? 8'h00 : 8'h20;
        m_left = 0; m_have_q = 0; m_done = 1'b0; m_count = 8'd0;
    endfunction

    function automatic void model_publish();
        for (int i = 0; i < 32; i++) m_frame[i] = 8'h20;
        m_frame[0]  = 8'h41; m_frame[1]  = 8'h3A;
        m_frame[16] = 8'h42; m_frame[17] = 8'h3A;
        for (int k = 0; k < 8; k++) begin
            m_frame[2 + k]  = hx[int'((m_cur_a >> (28 - 4 * k)) & 32'hF)];
            m_frame[18 + k] = hx[int'((m_cur_b >> (28 - 4 * k)) & 32'hF)];
        end
        m_frame[15] = 8'h00;
    endfunction

    function automatic void model_start(input logic [31:0] a, input logic [31:0] b);
        m_cur_a = a; m_cur_b = b; m_left = 33;
    endfunction

    function automatic void model_step(input logic l, input logic [31:0] a, input logic [31:0] b);
        m_done = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                model_publish();
                m_count++;
                m_done = 1'b1;
                if (l) begin
                    model_start(a, b); m_have_q = 0;
                end else if (m_have_q) begin
                    model_start(m_q_a, m_q_b); m_have_q = 0;
                end
            end else if (l) begin
                m_q_a = a; m_q_b = b; m_have_q = 1;
            end
        end else if (l) begin
            model_start(a, b);
        end
    endfunction

    task automatic drive_cycle(input logic l, input logic [31:0] a, input logic [31:0] b);
        bus.load = l; bus.a_val = a; bus.b_val = b;
        @(posedge clk);
        model_step(l, a, b);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.load = 1'b0; bus.a_val = '0; bus.b_val = '0; bus.sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            bus.sel = 5'(i); #0.2;
            n_checks++;
            if (bus.dd_data !== m_frame[i]) begin
                n_fail++; $display("FAIL reset_char sel=%0d got=%h want=%h", i, bus.dd_data, m_frame[i]);
            end
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.frame_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_status busy=%b done=%b count=%0d want 0/0/0", bus.busy, bus.done, bus.frame_count);
        end
    endtask

    task automatic test_single_load();
        int t_sel [7] = '{0, 1, 2, 9, 16, 18, 25};
        logic [7:0] t_exp [7] = '{8'h41, 8'h3A, 8'h31, 8'h44, 8'h42, 8'h44, 8'h46};
        bus.sel = 5'd2;
        drive_cycle(1'b1, 32'h1234ABCD, 32'hDEADBEEF);
        for (int c = 0; c < 33; c++) begin
            n_checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dd_data !== 8'h20) begin
                n_fail++; $display("FAIL single_busy cycle=%0d busy=%b done=%b dd=%h want 1/0/20", c, bus.busy, bus.done, bus.dd_data);
            end
            drive_cycle(1'b0, '0, '0);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.frame_count !== 8'd1) begin
            n_fail++; $display("FAIL single_done busy=%b done=%b count=%0d want 0/1/1", bus.busy, bus.done, bus.frame_count);
        end
        for (int i = 0; i < 7; i++) begin
            bus.sel = 5'(t_sel[i]); #0.2;
            n_checks++;
            if (bus.dd_data !== t_exp[i]) begin
                n_fail++; $display("FAIL single_char sel=%0d got=%h want=%h", t_sel[i], bus.dd_data, t_exp[i]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            bus.sel = 5'(i); #0.2;
            n_checks++;
            if (bus.dd_data !== m_frame[i]) begin
                n_fail++; $display("FAIL single_frame sel=%0d got=%h want=%h", i, bus.dd_data, m_frame[i]);
            end
        end
        drive_cycle(1'b0, '0, '0);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL single_done_width done=%b want 0", bus.done);
        end
    endtask

    task automatic test_no_tearing();
        bit seen = 0;
        bus.sel = 5'd5;
        drive_cycle(1'b1, 32'h0, $urandom);
        for (int c = 0; c < 40 && !seen; c++) begin
            n_checks++;
            if (bus.done === 1'b1) begin
                seen = 1;
                if (bus.dd_data !== 8'h30) begin
                    n_fail++; $display("FAIL tear_after got=%h want=30", bus.dd_data);
                end
            end else begin
                if (bus.dd_data !== 8'h34) begin
                    n_fail++; $display("FAIL tear_during cycle=%0d got=%h want=34", c, bus.dd_data);
                end
                drive_cycle(1'b0, '0, '0);
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL tear_timeout done=%b want 1", bus.done);
        end
    endtask

    task automatic test_queue();
        logic [7:0]  start_count = bus.frame_count;
        logic [31:0] z_a = $urandom;
        int          dones = 0;
        for (int c = 0; c < 90; c++) begin
            bus.sel = 5'($urandom);
            case (c)
                0:       drive_cycle(1'b1, $urandom, $urandom);
                4, 12:   drive_cycle(1'b1, $urandom, $urandom);
                20:      drive_cycle(1'b1, z_a, $urandom);
                default: drive_cycle(1'b0, $urandom, $urandom);
            endcase
            if (bus.done === 1'b1) dones++;
            n_checks++;
            if (bus.busy !== (m_left > 0) || bus.done !== m_done || bus.dd_data !== m_frame[bus.sel]) begin
                n_fail++; $display("FAIL queue_cycle c=%0d busy=%b done=%b dd=%h want %b/%b/%h",
                                   c, bus.busy, bus.done, bus.dd_data, m_left > 0, m_done, m_frame[bus.sel]);
            end
        end
        n_checks++;
        if (dones != 2 || bus.frame_count !== start_count + 8'd2) begin
            n_fail++; $display("FAIL queue_count dones=%0d count=%0d want 2/%0d", dones, bus.frame_count, start_count + 8'd2);
        end
        for (int k = 0; k < 8; k++) begin
            bus.sel = 5'(2 + k); #0.2;
            n_checks++;
            if (bus.dd_data !== hx[int'((z_a >> (28 - 4 * k)) & 32'hF)]) begin
                n_fail++; $display("FAIL queue_last pos=%0d got=%h want=%h", 2 + k, bus.dd_data, hx[int'((z_a >> (28 - 4 * k)) & 32'hF)]);
            end
        end
    endtask

    task automatic test_swap_load();
        logic [31:0] s_a = $urandom, s_b = $urandom;
        bit gap = 0, seen = 0;
        drive_cycle(1'b1, $urandom, $urandom);
        for (int c = 0; c < 40 && m_left != 1; c++) drive_cycle(1'b0, '0, '0);
        drive_cycle(1'b1, s_a, s_b);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL swap_edge done=%b busy=%b want 1/1", bus.done, bus.busy);
        end
        for (int c = 0; c < 40 && !seen; c++) begin
            drive_cycle(1'b0, '0, '0);
            if (bus.done === 1'b1) seen = 1;
            else if (bus.busy !== 1'b1) gap = 1;
        end
        n_checks++;
        if (gap || !seen) begin
            n_fail++; $display("FAIL swap_gap gap=%0d seen_done=%0d want 0/1", gap, seen);
        end
        for (int i = 0; i < 32; i++) begin
            bus.sel = 5'(i); #0.2;
            n_checks++;
            if (bus.dd_data !== m_frame[i]) begin
                n_fail++; $display("FAIL swap_frame sel=%0d got=%h want=%h", i, bus.dd_data, m_frame[i]);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        drive_cycle(1'b1, $urandom, $urandom);
        repeat (21) drive_cycle(1'b0, '0, '0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.frame_count !== 8'd0) begin
            n_fail++; $display("FAIL midrst_status busy=%b done=%b count=%0d want 0/0/0", bus.busy, bus.done, bus.frame_count);
        end
        for (int i = 0; i < 32; i++) begin
            bus.sel = 5'(i); #0.2;
            n_checks++;
            if (bus.dd_data !== m_frame[i]) begin
                n_fail++; $display("FAIL midrst_char sel=%0d got=%h want=%h", i, bus.dd_data, m_frame[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, $urandom, $urandom);
        repeat (33) drive_cycle(1'b0, '0, '0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.frame_count !== 8'd1) begin
            n_fail++; $display("FAIL midrst_reload done=%b count=%0d want 1/1", bus.done, bus.frame_count);
        end
        for (int i = 0; i < 32; i++) begin
            bus.sel = 5'(i); #0.2;
            n_checks++;
            if (bus.dd_data !== m_frame[i]) begin
                n_fail++; $display("FAIL midrst_frame sel=%0d got=%h want=%h", i, bus.dd_data, m_frame[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            bus.sel = 5'($urandom);
            drive_cycle($urandom_range(0, 15) == 0, $urandom, $urandom);
            n_checks++;
            if (bus.busy !== (m_left > 0) || bus.done !== m_done || bus.frame_count !== m_count
                || bus.dd_data !== m_frame[bus.sel]) begin
                n_fail++; $display("FAIL random c=%0d busy=%b done=%b count=%0d dd=%h want %b/%b/%0d/%h",
                                   c, bus.busy, bus.done, bus.frame_count, bus.dd_data,
                                   m_left > 0, m_done, m_count, m_frame[bus.sel]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_no_tearing();
        test_queue();
        test_swap_load();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
